// File: rtl/reset_cds_sequencer_pkg.sv
// Shared types and defaults for the LCMS readout CDS sequencer.
// Holds the FSM state encoding and default widths.
package lcms_readout_pkg;

    localparam int CNT_W_DEF = 16;
    localparam int ADC_W_DEF = 16;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        SETTLE,
        CONV_A,
        INTEG,
        CONV_B,
        EMIT
    } state_e;

    // States in which a re-asserted pixel reset aborts the frame
    function automatic logic is_active(state_e s);
        return s inside {SETTLE, CONV_A, INTEG, CONV_B};
    endfunction

endpackage

// File: rtl/reset_cds_sequencer_if.sv
// ADC start/done handshake between the CDS sequencer and the converter.
// The sequencer is master; the ADC is slave.
interface reset_cds_sequencer_if #(
    parameter int ADC_W = lcms_readout_pkg::ADC_W_DEF
) ();

    logic             adc_start;
    logic             adc_done;
    logic [ADC_W-1:0] adc_data;

    modport master (
        output adc_start,
        input  adc_done,
        input  adc_data
    );

    modport slave (
        input  adc_start,
        output adc_done,
        output adc_data
    );

endinterface

// File: rtl/reset_cds_sequencer_counter.sv
// Loadable down-counter shared by the settle and integration intervals.
// Saturates at zero; zero flag is a decode of the register.
module interval_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/reset_cds_sequencer.sv
// Correlated-double-sample sequencer driven by the pixel reset train.
// Converts reset level A and signal level B per frame and emits B - A.
module reset_cds_sequencer
    import lcms_readout_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int ADC_W = ADC_W_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    reset_pulse,
    input  logic [CNT_W-1:0]        settle_time,
    input  logic [CNT_W-1:0]        integ_time,
    reset_cds_sequencer_if.master   adc,
    output logic                    cds_valid,
    output logic signed [ADC_W:0]   cds_value,
    output logic [CNT_W-1:0]        frame_count,
    output logic                    overrun
);

    state_e state_q, state_d;
    logic rp_q;
    logic start_q, start_d;
    logic [ADC_W-1:0] a_q, a_d;
    logic [ADC_W:0] cds_q, cds_d;
    logic [CNT_W-1:0] fc_q, fc_d;
    logic ovr_q, ovr_d;

    logic rel;
    logic abt;
    logic ld;
    logic dec;
    logic zero;
    logic [CNT_W-1:0] ld_val;

    assign rel = rp_q && !reset_pulse;
    assign abt = reset_pulse && is_active(state_q);

    interval_counter #(.W(CNT_W)) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (ld),
        .dec      (dec),
        .load_val (ld_val),
        .zero     (zero)
    );

    always_comb begin
        state_d = state_q;
        start_d = 1'b0;
        a_d     = a_q;
        cds_d   = cds_q;
        fc_d    = fc_q;
        ovr_d   = ovr_q;
        ld      = 1'b0;
        dec     = 1'b0;
        ld_val  = settle_time;
        // Disable beats abort; abort beats expiry and adc_done
        if (!enable) begin
            state_d = IDLE;
        end else if (abt) begin
            state_d = ARM;
            ovr_d   = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: state_d = ARM;
                ARM: begin
                    if (rel) begin
                        state_d = SETTLE;
                        ld      = 1'b1;
                    end
                end
                SETTLE: begin
                    if (zero) begin
                        state_d = CONV_A;
                        start_d = 1'b1;
                    end else begin
                        dec = 1'b1;
                    end
                end
                CONV_A: begin
                    if (adc.adc_done) begin
                        a_d     = adc.adc_data;
                        ld      = 1'b1;
                        ld_val  = integ_time;
                        state_d = INTEG;
                    end
                end
                INTEG: begin
                    if (zero) begin
                        state_d = CONV_B;
                        start_d = 1'b1;
                    end else begin
                        dec = 1'b1;
                    end
                end
                CONV_B: begin
                    if (adc.adc_done) begin
                        cds_d   = {1'b0, adc.adc_data} - {1'b0, a_q};
                        fc_d    = fc_q + 1'b1;
                        state_d = EMIT;
                    end
                end
                EMIT: state_d = ARM;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rp_q    <= 1'b1;
            start_q <= 1'b0;
            a_q     <= '0;
            cds_q   <= '0;
            fc_q    <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rp_q    <= reset_pulse;
            start_q <= start_d;
            a_q     <= a_d;
            cds_q   <= cds_d;
            fc_q    <= fc_d;
            ovr_q   <= ovr_d;
        end
    end

    assign adc.adc_start = start_q;
    assign cds_valid     = (state_q == EMIT);
    assign cds_value     = cds_q;
    assign frame_count   = fc_q;
    assign overrun       = ovr_q;

endmodule

// File: doc/reset_cds_sequencer.md
Name: reset_cds_sequencer

Overview:
- Downstream consumer of the pixel reset pulse train produced by the periodic reset generator, which outputs low_time µs low and high_time µs high at a 1 MHz clk.
- On each reset release, the block sequences a correlated-double-sample: it converts once after a settle delay (reset level A) and once after an integration interval (signal level B).
- Emits B − A per frame, plus a frame count and an overrun flag.
- Drives the ADC start/done handshake on the LCMS sensor readout path.

Parameters:
CNT_W, 16, width of the settle/integ interval counters and of frame_count
ADC_W, 16, ADC sample width; cds_value is ADC_W+1 bits signed

Ports:
clk  in  1  system clock (1 MHz in the sensor build)
reset  in  1  synchronous, active-high; one clock domain (clk) only
enable  in  1  sequencer run enable; low forces IDLE
reset_pulse  in  1  pixel reset from reset generator (1 = pixel in reset)
settle_time  in  CNT_W  cycles from release detect to conversion A start
integ_time  in  CNT_W  cycles from conversion A done to conversion B start
adc_start  out  1  single-cycle conversion request
adc_done  in  1  single-cycle conversion complete, qualifies adc_data
adc_data  in  ADC_W  unsigned conversion result
cds_valid  out  1  single-cycle pulse, new cds_value
cds_value  out  ADC_W+1  signed B − A, held until next cds_valid
frame_count  out  CNT_W  completed frames, wraps 2^CNT_W−1 → 0
overrun  out  1  sticky: frame aborted by early reset assertion; cleared only by reset

Behaviour:
- reset (sync): state=IDLE; adc_start=0, cds_valid=0, cds_value=0, frame_count=0, overrun=0; reset_pulse history register=1, so no false release is detected on exit.
- Release event (REL): reset_pulse sampled 0 at this edge and 1 at the previous edge.
- Abort event (ABT): reset_pulse sampled 1 while in SETTLE, CONV_A, INTEG or CONV_B.
- States and transitions:
  - IDLE: go to ARM when enable=1.
  - ARM: wait for REL, then go to SETTLE and load counter with settle_time.
  - SETTLE: count down. When the counter reaches 0, assert adc_start for exactly one cycle and go to CONV_A. With settle_time=0, adc_start is high in the cycle immediately after REL. In general adc_start is high settle_time+1 cycles after the REL edge.
  - CONV_A: on adc_done, latch A=adc_data, load integ_time, go to INTEG.
  - INTEG: same counting rule as SETTLE. adc_start is high integ_time+1 cycles after the adc_done(A) edge; then go to CONV_B.
  - CONV_B: on adc_done, compute cds_value = {0,B} − {0,A} in ADC_W+1-bit two's complement. Pulse cds_valid the following cycle, increment frame_count in that same cycle, then return to ARM.
- ABT in any active state: return to ARM, set overrun, no cds_valid, frame_count unchanged, no adc_start in that cycle. ABT takes priority over counter expiry and over adc_done in the same cycle.
- enable=0 in any state: next state IDLE, adc_start suppressed. Outputs cds_value, frame_count and overrun hold.
- adc_done outside CONV_A/CONV_B is ignored. adc_start is never reasserted while a conversion is pending.
- reset_pulse stuck high (low_time=0): no REL, block stays in ARM, no adc_start.
- reset_pulse stuck low (high_time=0 case): at most one REL, one frame completes, then the block stays in ARM.
- Interval inputs are sampled only at counter load, so changes mid-frame take effect next frame.
- Reset asserted mid-frame: full reset values next cycle; any in-flight adc_done afterwards is ignored.

Decomposition:
- Package lcms_readout_pkg holds:
  - state encoding constants: IDLE, ARM, SETTLE, CONV_A, INTEG, CONV_B, EMIT
  - CNT_W and ADC_W defaults
- One sub-module: interval_counter (load value, decrement, zero flag, sync reset). It is instantiated once and reused for settle and integ.

Test Plan:
- Common setup for all scenarios: clk 1 MHz; reset generator low_time=98, high_time=2; ADC model returns adc_done 4 cycles after adc_start.
- Nominal frame: settle_time=3, integ_time=50, A=100, B=400 → first adc_start 4 cycles after REL, second 51 cycles after done(A); cds_value=+300; frame_count 0→1; overrun=0.
- Negative result: A=500, B=20 → cds_value = −480 (17'h1FE20); cds_valid exactly one cycle wide.
- Overrun: integ_time=200 → ABT during INTEG; overrun=1, no cds_valid, frame_count unchanged. Then integ_time=50 → next frame completes normally and overrun stays 1.
- Stuck levels:
  - low_time=0, high_time=65535 → zero adc_start over 1 ms.
  - high_time=0 → exactly one frame, then idle in ARM.
- Disruptions:
  - Drop enable during INTEG → IDLE, no adc_start; after re-enable, the next REL starts a fresh frame.
  - Assert reset during CONV_B → all outputs return to reset values, and a late adc_done produces no cds_valid.
- Wrap: preload via 65536 frames (settle=0, integ=0) → frame_count 65535→0.
